mem_write_buffer: RTL and testbench

Line-granular posted-write buffer between the CPU's data-cache memory port and the main data memory. It accepts 256-bit dirty-line write-backs from the cache and acknowledges them without waiting for memory, then drains them to memory in FIFO order. Reads that hit a buffered line are answered from the buffer; read misses are forwarded to memory ahead of pending drains.

---
 rtl/mem_write_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted line write buffer between the data-cache memory port and main memory.
// Write-backs are acknowledged at once and drained in FIFO order; reads are served from the buffer or forwarded.
//
// state | meaning
// IDLE  | memory port free; choose the pending read miss or the next drain
// DRAIN | head line being written to memory
// READ  | read miss outstanding at memory
// RESP  | cycle in which the read-miss line is returned to the cache
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             c_enable_i,
  input  logic             c_write_i,
  input  logic [31:0]      c_addr_i,
  input  logic [255:0]     c_data_i,
  output logic             c_ack_o,
  output logic [255:0]     c_data_o,
  output logic             m_enable_o,
  output logic             m_write_o,
  output logic [31:0]      m_addr_o,
  output logic [255:0]     m_data_o,
  input  logic             m_ack_i,
  input  logic [255:0]     m_data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [26:0]        tag_q  [DEPTH];
  logic [26:0]        tag_d  [DEPTH];
  logic [255:0]       line_q [DEPTH];
  logic [255:0]       line_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;
  logic               c_ack_q, c_ack_d;
  logic [255:0]       c_data_q, c_data_d;
  logic               m_enable_q, m_enable_d;
  logic               m_write_q, m_write_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [255:0]       m_data_q, m_data_d;
  logic               rd_wait_q, rd_wait_d;
  logic [26:0]        rd_tag_q, rd_tag_d;

  logic               req_take, head_busy, pop, enq, rd_miss;
  logic               wr_hit, rd_hit;
  logic [PTR_W-1:0]   wr_idx, rd_idx, scan_idx;
  logic [26:0]        req_tag;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^c_addr_i[4:0];

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    line_d     = line_q;
    head_d     = head_q;
    tail_d     = tail_q;
    c_ack_d    = 1'b0;
    c_data_d   = c_data_q;
    m_enable_d = m_enable_q;
    m_write_d  = m_write_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    rd_wait_d  = rd_wait_q;
    rd_tag_d   = rd_tag_q;
    enq        = 1'b0;
    rd_miss    = 1'b0;
    wr_hit     = 1'b0;
    rd_hit     = 1'b0;
    wr_idx     = '0;
    rd_idx     = '0;
    scan_idx   = '0;

    req_take  = c_enable_i && !c_ack_q && !rd_wait_q;
    req_tag   = c_addr_i[31:5];
    head_busy = m_enable_q && m_write_q;

    // Scan oldest to youngest so the last match is the youngest copy.
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + PTR_W'(k);
      if (valid_q[scan_idx] && (tag_q[scan_idx] == req_tag)) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
        if (!(head_busy && (scan_idx == head_q))) begin
          wr_hit = 1'b1;
          wr_idx = scan_idx;
        end
      end
    end

    if (req_take) begin
      if (c_write_i) begin
        if (wr_hit) begin
          line_d[wr_idx] = c_data_i;
          c_ack_d        = 1'b1;
        end else if (count_q < CNT_W'(DEPTH)) begin
          enq            = 1'b1;
          valid_d[tail_q] = 1'b1;
          tag_d[tail_q]  = req_tag;
          line_d[tail_q] = c_data_i;
          tail_d         = tail_q + 1'b1;
          c_ack_d        = 1'b1;
        end
      end else if (rd_hit) begin
        c_ack_d  = 1'b1;
        c_data_d = line_q[rd_idx];
      end else begin
        rd_miss   = 1'b1;
        rd_wait_d = 1'b1;
        rd_tag_d  = req_tag;
      end
    end

    pop = (state_q == DRAIN) && m_ack_i;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    empty_d = (count_d == '0);

    unique case (state_q)
      IDLE: begin
        if (rd_wait_q || rd_miss) begin
          state_d    = READ;
          m_enable_d = 1'b1;
          m_write_d  = 1'b0;
          m_addr_d   = {(rd_wait_q ? rd_tag_q : req_tag), 5'b0};
        end else if (count_q != '0) begin
          // Taken from the _d copy so a coalesce into the head at this edge is not lost.
          state_d    = DRAIN;
          m_enable_d = 1'b1;
          m_write_d  = 1'b1;
          m_addr_d   = {tag_d[head_q], 5'b0};
          m_data_d   = line_d[head_q];
        end
      end
      DRAIN: begin
        if (m_ack_i) begin
          m_enable_d = 1'b0;
          state_d    = IDLE;
        end
      end
      READ: begin
        if (m_ack_i) begin
          m_enable_d = 1'b0;
          c_ack_d    = 1'b1;
          c_data_d   = m_data_i;
          state_d    = RESP;
        end
      end
      RESP: begin
        rd_wait_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '{default: '0};
      line_q     <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      c_ack_q    <= 1'b0;
      c_data_q   <= '0;
      m_enable_q <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      rd_wait_q  <= 1'b0;
      rd_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      line_q     <= line_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      c_ack_q    <= c_ack_d;
      c_data_q   <= c_data_d;
      m_enable_q <= m_enable_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      rd_wait_q  <= rd_wait_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  assign c_ack_o    = c_ack_q;
  assign c_data_o   = c_data_q;
  assign m_enable_o = m_enable_q;
  assign m_write_o  = m_write_q;
  assign m_addr_o   = m_addr_q;
  assign m_data_o   = m_data_q;
  assign count_o    = count_q;
  assign empty_o    = empty_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: cycle table for write/drain/coalesce/read-hit,
// then hand sequences for full stall, read-miss forwarding and mid-drain reset.
module tb_mem_write_buffer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         c_enable_i, c_write_i;
  logic [31:0]  c_addr_i;
  logic [255:0] c_data_i;
  logic         c_ack_o;
  logic [255:0] c_data_o;
  logic         m_enable_o, m_write_o;
  logic [31:0]  m_addr_o;
  logic [255:0] m_data_o;
  logic         m_ack_i;
  logic [255:0] m_data_i;
  logic [2:0]   count_o;
  logic         empty_o;

  int checks = 0;
  int failures = 0;

  mem_write_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .c_enable_i(c_enable_i), .c_write_i(c_write_i), .c_addr_i(c_addr_i), .c_data_i(c_data_i),
    .c_ack_o(c_ack_o), .c_data_o(c_data_o),
    .m_enable_o(m_enable_o), .m_write_o(m_write_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_ack_i(m_ack_i), .m_data_i(m_data_i),
    .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         c_en;
    logic         c_wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic         m_ack;
    logic         e_c_ack;
    logic [255:0] e_c_data;
    logic         e_m_en;
    logic         e_m_wr;
    logic [31:0]  e_m_addr;
    logic [255:0] e_m_data;
    logic [2:0]   e_count;
  } vec_t;

  localparam logic [255:0] LA = {8{32'hA5A5_0001}};
  localparam logic [255:0] D1 = 256'd1;
  localparam logic [255:0] D2 = 256'd2;
  localparam logic [255:0] D3 = 256'd3;
  localparam logic [255:0] DEAD = 256'hDEAD;

  vec_t vecs[18];

  function automatic vec_t mk(input logic c_en, input logic c_wr, input logic [31:0] addr,
                              input logic [255:0] wdata, input logic m_ack, input logic e_c_ack,
                              input logic [255:0] e_c_data, input logic e_m_en, input logic e_m_wr,
                              input logic [31:0] e_m_addr, input logic [255:0] e_m_data,
                              input logic [2:0] e_count);
    vec_t v;
    v.c_en = c_en; v.c_wr = c_wr; v.addr = addr; v.wdata = wdata; v.m_ack = m_ack;
    v.e_c_ack = e_c_ack; v.e_c_data = e_c_data; v.e_m_en = e_m_en; v.e_m_wr = e_m_wr;
    v.e_m_addr = e_m_addr; v.e_m_data = e_m_data; v.e_count = e_count;
    return v;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] addr);
    return {8{addr ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cache_req(input string nm, input logic wr, input logic [31:0] addr,
                           input logic [255:0] data, output logic [255:0] rdata);
    logic got;
    got = 1'b0;
    rdata = '0;
    c_enable_i = 1'b1; c_write_i = wr; c_addr_i = addr; c_data_i = data;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_i); #1;
      if (c_ack_o) begin
        got = 1'b1;
        rdata = c_data_o;
      end
    end
    c_enable_i = 1'b0; c_write_i = 1'b0;
    chk({nm, " ack"}, 256'(got), 256'(1'b1));
  endtask

  task automatic mem_serve(input string nm, input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [255:0] exp_data, input int lat, input logic [255:0] rdata);
    logic seen;
    seen = m_enable_o;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk_i); #1;
      seen = m_enable_o;
    end
    chk({nm, " m_enable"}, 256'(seen), 256'(1'b1));
    if (seen) begin
      chk({nm, " m_write"}, 256'(m_write_o), 256'(exp_wr));
      chk({nm, " m_addr"}, 256'(m_addr_o), 256'(exp_addr));
      if (exp_wr) chk({nm, " m_data"}, m_data_o, exp_data);
      for (int i = 0; i < lat; i++) begin
        @(posedge clk_i); #1;
      end
      m_ack_i = 1'b1; m_data_i = rdata;
      @(posedge clk_i); #1;
      m_ack_i = 1'b0; m_data_i = '0;
      chk({nm, " m_enable drop"}, 256'(m_enable_o), 256'(1'b0));
      if (!exp_wr) begin
        chk({nm, " resp c_ack"}, 256'(c_ack_o), 256'(1'b1));
        chk({nm, " resp c_data"}, c_data_o, rdata);
      end
    end
  endtask

  logic [255:0] rd;
  logic         ack_seen;

  initial begin
    rst_i = 1'b1;
    c_enable_i = 1'b0; c_write_i = 1'b0; c_addr_i = '0; c_data_i = '0;
    m_ack_i = 1'b0; m_data_i = '0;

    //          en wr addr   wdata m_ack| c_ack c_data en wr  m_addr m_data cnt
    vecs[0]  = mk(1, 1, 32'h040, LA, 0,  1, '0, 0, 0, 32'h000, '0, 3'd1);
    vecs[1]  = mk(0, 0, 32'h000, '0, 0,  0, '0, 1, 1, 32'h040, LA, 3'd1);
    vecs[2]  = mk(0, 0, 32'h000, '0, 0,  0, '0, 1, 1, 32'h040, LA, 3'd1);
    vecs[3]  = mk(0, 0, 32'h000, '0, 0,  0, '0, 1, 1, 32'h040, LA, 3'd1);
    vecs[4]  = mk(0, 0, 32'h000, '0, 1,  0, '0, 0, 1, 32'h040, LA, 3'd0);
    vecs[5]  = mk(0, 0, 32'h000, '0, 0,  0, '0, 0, 1, 32'h040, LA, 3'd0);
    vecs[6]  = mk(1, 1, 32'h080, D1, 0,  1, '0, 0, 1, 32'h040, LA, 3'd1);
    vecs[7]  = mk(1, 1, 32'h100, D2, 0,  0, '0, 1, 1, 32'h080, D1, 3'd1);
    vecs[8]  = mk(1, 1, 32'h100, D2, 0,  1, '0, 1, 1, 32'h080, D1, 3'd2);
    vecs[9]  = mk(1, 1, 32'h100, D3, 0,  0, '0, 1, 1, 32'h080, D1, 3'd2);
    vecs[10] = mk(1, 1, 32'h100, D3, 0,  1, '0, 1, 1, 32'h080, D1, 3'd2);
    vecs[11] = mk(1, 0, 32'h100, '0, 0,  0, '0, 1, 1, 32'h080, D1, 3'd2);
    vecs[12] = mk(1, 0, 32'h100, '0, 0,  1, D3, 1, 1, 32'h080, D1, 3'd2);
    vecs[13] = mk(0, 0, 32'h000, '0, 0,  0, D3, 1, 1, 32'h080, D1, 3'd2);
    vecs[14] = mk(0, 0, 32'h000, '0, 1,  0, D3, 0, 1, 32'h080, D1, 3'd1);
    vecs[15] = mk(0, 0, 32'h000, '0, 0,  0, D3, 1, 1, 32'h100, D3, 3'd1);
    vecs[16] = mk(0, 0, 32'h000, '0, 1,  0, D3, 0, 1, 32'h100, D3, 3'd0);
    vecs[17] = mk(0, 0, 32'h000, '0, 0,  0, D3, 0, 1, 32'h100, D3, 3'd0);

    repeat (2) @(posedge clk_i);
    #1;
    chk("reset c_ack", 256'(c_ack_o), 256'(1'b0));
    chk("reset m_enable", 256'(m_enable_o), 256'(1'b0));
    chk("reset count", 256'(count_o), 256'(3'd0));
    chk("reset empty", 256'(empty_o), 256'(1'b1));
    rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      c_enable_i = vecs[i].c_en; c_write_i = vecs[i].c_wr;
      c_addr_i = vecs[i].addr; c_data_i = vecs[i].wdata; m_ack_i = vecs[i].m_ack;
      @(posedge clk_i); #1;
      chk($sformatf("v%0d c_ack", i), 256'(c_ack_o), 256'(vecs[i].e_c_ack));
      chk($sformatf("v%0d c_data", i), c_data_o, vecs[i].e_c_data);
      chk($sformatf("v%0d m_enable", i), 256'(m_enable_o), 256'(vecs[i].e_m_en));
      chk($sformatf("v%0d m_write", i), 256'(m_write_o), 256'(vecs[i].e_m_wr));
      chk($sformatf("v%0d m_addr", i), 256'(m_addr_o), 256'(vecs[i].e_m_addr));
      chk($sformatf("v%0d m_data", i), m_data_o, vecs[i].e_m_data);
      chk($sformatf("v%0d count", i), 256'(count_o), 256'(vecs[i].e_count));
      chk($sformatf("v%0d empty", i), 256'(empty_o), 256'(vecs[i].e_count == 3'd0));
    end
    c_enable_i = 1'b0; c_write_i = 1'b0; m_ack_i = 1'b0;

    // Full stall: memory never acks until four lines are held.
    for (int a = 0; a < 4; a++) begin
      cache_req($sformatf("stall wr%0d", a), 1'b1, 32'(a * 32), line_of(32'(a * 32)), rd);
    end
    chk("stall count full", 256'(count_o), 256'(3'd4));
    chk("stall head addr", 256'(m_addr_o), 256'(32'h000));
    c_enable_i = 1'b1; c_write_i = 1'b1; c_addr_i = 32'h080; c_data_i = line_of(32'h080);
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      ack_seen = ack_seen | c_ack_o;
    end
    chk("stall fifth no ack", 256'(ack_seen), 256'(1'b0));
    m_ack_i = 1'b1;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    chk("stall pop count", 256'(count_o), 256'(3'd3));
    chk("stall pop edge no ack", 256'(c_ack_o), 256'(1'b0));
    @(posedge clk_i); #1;
    chk("stall admit ack", 256'(c_ack_o), 256'(1'b1));
    chk("stall admit count", 256'(count_o), 256'(3'd4));
    c_enable_i = 1'b0; c_write_i = 1'b0;
    mem_serve("drain 020", 1'b1, 32'h020, line_of(32'h020), 1, '0);
    mem_serve("drain 040", 1'b1, 32'h040, line_of(32'h040), 1, '0);
    mem_serve("drain 060", 1'b1, 32'h060, line_of(32'h060), 1, '0);
    mem_serve("drain 080", 1'b1, 32'h080, line_of(32'h080), 1, '0);
    @(posedge clk_i); #1;
    chk("stall final count", 256'(count_o), 256'(3'd0));
    chk("stall final empty", 256'(empty_o), 256'(1'b1));

    // Read miss overtakes the queued 0x100 drain.
    cache_req("rm wr080", 1'b1, 32'h080, D1, rd);
    cache_req("rm wr100", 1'b1, 32'h100, D2, rd);
    chk("rm drain in flight", 256'(m_addr_o), 256'(32'h080));
    fork
      begin
        cache_req("rm read200", 1'b0, 32'h200, '0, rd);
        chk("rm read data", rd, DEAD);
      end
      begin
        mem_serve("rm drain 080", 1'b1, 32'h080, D1, 2, '0);
        mem_serve("rm fetch 200", 1'b0, 32'h200, '0, 1, DEAD);
        mem_serve("rm drain 100", 1'b1, 32'h100, D2, 1, '0);
      end
    join
    @(posedge clk_i); #1;
    chk("rm final count", 256'(count_o), 256'(3'd0));

    // Reset in the middle of a drain with three lines held.
    cache_req("rst wr300", 1'b1, 32'h300, line_of(32'h300), rd);
    cache_req("rst wr320", 1'b1, 32'h320, line_of(32'h320), rd);
    cache_req("rst wr340", 1'b1, 32'h340, line_of(32'h340), rd);
    chk("rst pre count", 256'(count_o), 256'(3'd3));
    chk("rst pre m_enable", 256'(m_enable_o), 256'(1'b1));
    #2 rst_i = 1'b1;
    #1;
    chk("rst c_ack", 256'(c_ack_o), 256'(1'b0));
    chk("rst c_data", c_data_o, '0);
    chk("rst m_enable", 256'(m_enable_o), 256'(1'b0));
    chk("rst m_write", 256'(m_write_o), 256'(1'b0));
    chk("rst m_addr", 256'(m_addr_o), '0);
    chk("rst m_data", m_data_o, '0);
    chk("rst count", 256'(count_o), 256'(3'd0));
    chk("rst empty", 256'(empty_o), 256'(1'b1));
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    m_ack_i = 1'b1;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0;
    chk("stray ack count", 256'(count_o), 256'(3'd0));
    chk("stray ack empty", 256'(empty_o), 256'(1'b1));
    chk("stray ack c_ack", 256'(c_ack_o), 256'(1'b0));
    @(posedge clk_i); #1;
    chk("stray ack m_enable", 256'(m_enable_o), 256'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
